// File: rtl/hapara_axis_mc_timestamp_logger.sv
// hapara_axis_mc_timestamp_logger: multi-channel rising-edge timestamp capture logged as tagged entries into a BRAM ring
//   clk/rst          : single clock, synchronous active-high reset
//   bram_*           : BRAM write port (bram_dout reserved, unused)
//   req/ack          : per-channel level request, completion level
//   drop             : sticky per-channel lost-event flag
//   wrapped          : sticky ring write pointer wrap flag
//   HAPARA_TS_DELTA_EN : when defined, timestamp words hold per-channel deltas and header MSB is set
module hapara_axis_mc_timestamp_logger #(
  parameter int DATA_WIDTH = 32,
  parameter int TS_WIDTH = 64,
  parameter int NUM_CH = 4,
  parameter int DEPTH_ENTRIES = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      bram_clk,
  output logic                      bram_rst,
  output logic                      bram_en,
  output logic [DATA_WIDTH/8-1:0]   bram_we,
  output logic [DATA_WIDTH-1:0]     bram_addr,
  output logic [DATA_WIDTH-1:0]     bram_din,
  input  logic [DATA_WIDTH-1:0]     bram_dout,
  input  logic [NUM_CH-1:0]         req,
  output logic [NUM_CH-1:0]         ack,
  output logic [NUM_CH-1:0]         drop,
  output logic                      wrapped
);
  localparam int K = TS_WIDTH / DATA_WIDTH;
  localparam int BPW = DATA_WIDTH / 8;
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int PW = $clog2(DEPTH_ENTRIES);
  localparam int KW = K > 1 ? $clog2(K) : 1;
  localparam int SW = DATA_WIDTH - 8;
  typedef enum logic [1:0] {IDLE, HDR, TSW, DONE} state_t;
  state_t state, state_n;
  logic [TS_WIDTH-1:0] counter;
  logic [TS_WIDTH-1:0] snap [NUM_CH];
  logic [NUM_CH-1:0] req_d, pend, rise, clr;
  logic [CW-1:0] g, g_sel, rr_ptr;
  logic found;
  logic [KW-1:0] beat;
  logic [PW-1:0] wr_ptr;
  logic [SW-1:0] seq;
  logic [TS_WIDTH-1:0] ts_val;
  logic [DATA_WIDTH-1:0] hdr, ts_word, word_idx;
  logic unused_dout;
  assign bram_clk = clk;
  assign bram_rst = rst;
  assign unused_dout = ^bram_dout;
  assign rise = req & ~req_d;
  // pend[g] is treated as already clear during DONE so a fresh rise there is captured
  assign clr = state == DONE ? NUM_CH'(1) << g : '0;
`ifdef HAPARA_TS_DELTA_EN
  logic [TS_WIDTH-1:0] prev [NUM_CH];
  assign ts_val = snap[g] - prev[g];
  assign hdr = {1'b1, seq[SW-2:0], 8'(g)};
`else
  assign ts_val = snap[g];
  assign hdr = {seq, 8'(g)};
`endif
  assign ts_word = DATA_WIDTH'(ts_val >> (int'(beat) * DATA_WIDTH));
  assign word_idx = DATA_WIDTH'(wr_ptr) * DATA_WIDTH'(K + 1) + (state == TSW ? DATA_WIDTH'(beat) + DATA_WIDTH'(1) : '0);
  always_comb begin
    g_sel = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (!found && pend[(int'(rr_ptr) + k) % NUM_CH]) begin
        g_sel = CW'((int'(rr_ptr) + k) % NUM_CH);
        found = 1'b1;
      end
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    bram_en = 1'b0;
    bram_we = '0;
    bram_addr = '0;
    bram_din = '0;
    state_n = state == IDLE ? (found ? HDR : IDLE) :
              state == HDR  ? TSW :
              state == TSW  ? (beat == KW'(K - 1) ? DONE : TSW) : IDLE;
    if (state == HDR || state == TSW) begin
      bram_en = 1'b1;
      bram_we = '1;
      bram_addr = DATA_WIDTH'(BASE_ADDR) + word_idx * DATA_WIDTH'(BPW);
      bram_din = state == HDR ? hdr : ts_word;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      counter <= '0;
      req_d <= '0;
      pend <= '0;
      ack <= '0;
      drop <= '0;
      wrapped <= 1'b0;
      wr_ptr <= '0;
      seq <= '0;
      rr_ptr <= '0;
      g <= '0;
      beat <= '0;
      for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
`ifdef HAPARA_TS_DELTA_EN
      for (int i = 0; i < NUM_CH; i++) prev[i] <= '0;
`endif
    end else begin
      counter <= counter + TS_WIDTH'(1);
      req_d <= req;
      pend <= (pend & ~clr) | rise;
      ack <= (ack | (clr & req)) & req;
      beat <= state == TSW ? beat + KW'(1) : '0;
      if (state == IDLE && found) g <= g_sel;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rise[i] && pend[i] && !clr[i]) drop[i] <= 1'b1;
        if (rise[i] && (!pend[i] || clr[i])) snap[i] <= counter;
      end
      if (state == DONE) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (&wr_ptr) wrapped <= 1'b1;
        seq <= seq + SW'(1);
        rr_ptr <= g == CW'(NUM_CH - 1) ? '0 : g + CW'(1);
`ifdef HAPARA_TS_DELTA_EN
        prev[g] <= snap[g];
`endif
      end
    end
endmodule
